xort_pulse_sched: RTL
=====================

// Module: xort_pulse_sched
// PURPOSE
//  Round-robin scheduler that shares one clocked-XOR (XORT) RSFQ cell among N_REQ requesters.
//  Sequences each transaction into the cell's pulse interface: operand pulses, then the clock pulse.
//  Samples the cell output and returns the result to the granted requester.
//  Every SFQ pulse on xort_a/xort_b/xort_clk/xort_out is one level toggle. Sits between the digital
//  control domain and the XORT cell model.
// PARAMETERS
//  N_REQ     4  number of requesters (>=2)
//  SETUP_CYC 2  cycles from operand pulses to clock pulse (>=1)
//  OUT_WAIT  3  cycles xort_out is watched after the clock pulse (>=1)
// PORTS
//  clk       in   1      host clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  req       in   N_REQ  request per requester; held high until ack
//  op_a      in   N_REQ  operand A per requester (1 = send pulse)
//  op_b      in   N_REQ  operand B per requester
//  grant     out  N_REQ  one-hot grant, high from arbitration until ack
//  ack       out  1      one-cycle completion strobe
//  res       out  1      XOR result, valid with ack
//  busy      out  1      high whenever state != IDLE
//  err       out  1      sticky: xort_out toggled more than once in one WAIT window
//  xort_a    out  1      toggle = pulse to cell input a
//  xort_b    out  1      toggle = pulse to cell input b
//  xort_clk  out  1      toggle = pulse to cell clk
//  xort_out  in   1      cell output; toggle = result pulse (synchronous to clk)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - grant=0, ack=0, res=0, busy=0, err=0; xort_a/b/clk=0.
//   - out_prev=0; rr pointer=0; state=IDLE.
//  Reset mid-transaction aborts it: no ack is issued, and the bench resets the cell model with it.
//  FSM: IDLE -> DRIVE -> SETUP -> WAIT -> RESP -> IDLE.
//  Timing, relative to edge E that leaves IDLE:
//   - IDLE, any req at edge E: the winner's grant bit sets; its op_a/op_b are latched; out_prev<=xort_out.
//   - E+1: xort_a toggles if latched A=1; xort_b toggles if latched B=1; both may toggle on the same edge.
//   - E+1+SETUP_CYC: xort_clk toggles.
//   - Edges E+2+SETUP_CYC .. E+1+SETUP_CYC+OUT_WAIT: count xort_out != out_prev changes (out_prev updates each edge).
//   - E+2+SETUP_CYC+OUT_WAIT: ack=1 for one cycle; res=(toggle count==1); grant clears on this edge.
//     If count>=2: err sets, and res=1 if the count is odd.
//  Latency, defaults: grant at E, ack at E+7. The next grant is no earlier than E+8 (IDLE lasts one cycle).
//  Arbitration: winner is the first requesting index strictly after the last winner, wrapping N_REQ-1 -> 0.
//   - After reset the search starts at index 0.
//   - The pointer updates only when a grant is issued.
//  req deasserted mid-transaction: the transaction still completes and ack is still issued; op changes are ignored.
//  No req in IDLE: no activity. xort_* outputs hold their level; xort_out changes are tracked only into out_prev.
//  err clears only on reset.
// CONFIGURATION
//  XORT_SCHED_RR_EN defined:   round-robin arbitration as above.
//  XORT_SCHED_RR_EN undefined: fixed priority, lowest requesting index wins; no pointer state.
//  All other behaviour and timing are identical in both builds.
// TESTING
//  1) rst_n=0 then 1, no req -> all outputs 0 for 20 cycles, busy=0.
//  2) req=0001, op_a[0]=1, op_b[0]=0; cell model returns one out toggle
//     -> grant=0001 at E; xort_a toggles at E+1; xort_clk at E+3; ack at E+7 with res=1.
//  3) req=0010, op_a[1]=1, op_b[1]=1; cell returns no toggle
//     -> xort_a and xort_b toggle together at E+1; ack at E+7 with res=0.
//  4) req=1111 held with RR_EN -> grants in order 0001,0010,0100,1000,0001, spaced 8 cycles.
//     Without RR_EN -> grant=0001 repeatedly.
//  5) Model injects 2 out toggles in WAIT -> err=1, res=0; err remains 1 across later transactions.
//  6) rst_n pulsed low at E+2 during a transaction -> no ack; all outputs 0; next req is served normally.

Source files
------------

// File: rtl/xort_pulse_sched_if.sv
// Requester-side bus of the XORT pulse scheduler: requests, operands, grant and result.
// The master side belongs to the requesters; the slave side belongs to the scheduler.
interface xort_pulse_sched_if #(
    parameter int unsigned N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] op_a;
    logic [N_REQ-1:0] op_b;
    logic [N_REQ-1:0] grant;
    logic             ack;
    logic             res;

    modport master (output req, op_a, op_b, input grant, ack, res);
    modport slave  (input req, op_a, op_b, output grant, ack, res);
endinterface

// File: rtl/xort_pulse_sched.sv
// Shares one clocked-XOR RSFQ cell among N_REQ requesters. Each SFQ pulse is a level toggle.
// XORT_SCHED_RR_EN selects round-robin arbitration; otherwise the lowest requesting index wins.
module xort_pulse_sched #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned OUT_WAIT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    xort_pulse_sched_if.slave bus,
    output logic              busy,
    output logic              err,
    output logic              xort_a,
    output logic              xort_b,
    output logic              xort_clk,
    input  logic              xort_out
);
    localparam int unsigned IW   = $clog2(N_REQ);
    localparam int unsigned CMAX = (SETUP_CYC > OUT_WAIT) ? SETUP_CYC : OUT_WAIT;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned TW   = $clog2(OUT_WAIT + 1);

    typedef enum logic [2:0] {StIdle, StDrive, StSetup, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             ack_q, ack_d;
    logic             res_q, res_d;
    logic             err_q, err_d;
    logic             xa_q, xa_d;
    logic             xb_q, xb_d;
    logic             xclk_q, xclk_d;
    logic             opa_q, opa_d;
    logic             opb_q, opb_d;
    logic             out_prev_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tog_q, tog_d;
    logic             found;
    logic [IW-1:0]    win;

`ifdef XORT_SCHED_RR_EN
    // ptr_q holds the index where the next search starts (one past the last winner).
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = IW'((32'(ptr_q) + i) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StIdle && found) begin
            ptr_d = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && bus.req[IW'(i)]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = 1'b0;
        res_d   = 1'b0;
        err_d   = err_q;
        xa_d    = xa_q;
        xb_d    = xb_q;
        xclk_d  = xclk_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    opa_d        = bus.op_a[win];
                    opb_d        = bus.op_b[win];
                    state_d      = StDrive;
                end
            end
            StDrive: begin
                if (opa_q) xa_d = ~xa_q;
                if (opb_q) xb_d = ~xb_q;
                cnt_d   = '0;
                state_d = StSetup;
            end
            StSetup: begin
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    xclk_d  = ~xclk_q;
                    cnt_d   = '0;
                    tog_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWait: begin
                if (xort_out != out_prev_q) tog_d = tog_q + TW'(1);
                if (cnt_q == CW'(OUT_WAIT - 1)) state_d = StResp;
                else                            cnt_d   = cnt_q + CW'(1);
            end
            StResp: begin
                // An odd toggle count reads as a 1; more than one toggle is a cell fault.
                ack_d   = 1'b1;
                res_d   = tog_q[0];
                if (tog_q > TW'(1)) err_d = 1'b1;
                grant_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            ack_q      <= 1'b0;
            res_q      <= 1'b0;
            err_q      <= 1'b0;
            xa_q       <= 1'b0;
            xb_q       <= 1'b0;
            xclk_q     <= 1'b0;
            opa_q      <= 1'b0;
            opb_q      <= 1'b0;
            out_prev_q <= 1'b0;
            cnt_q      <= '0;
            tog_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            res_q      <= res_d;
            err_q      <= err_d;
            xa_q       <= xa_d;
            xb_q       <= xb_d;
            xclk_q     <= xclk_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            out_prev_q <= xort_out;
            cnt_q      <= cnt_d;
            tog_q      <= tog_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;
    assign bus.res   = res_q;
    assign busy      = (state_q != StIdle);
    assign err       = err_q;
    assign xort_a    = xa_q;
    assign xort_b    = xb_q;
    assign xort_clk  = xclk_q;
endmodule
